// File: rtl/wash_seq_pkg.sv
// Shared encodings for the multi-machine wash sequencer.
// State codes and setting-field selectors.
package wash_seq_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WASH  = 3'd1,
        ST_RINSE = 3'd2,
        ST_SPIN  = 3'd3,
        ST_DONE  = 3'd4
    } wash_state_e;

    localparam logic [1:0] FLD_WASH  = 2'd0;
    localparam logic [1:0] FLD_RINSE = 2'd1;
    localparam logic [1:0] FLD_SPIN  = 2'd2;
    localparam logic [1:0] FLD_CLOTH = 2'd3;

endpackage

// File: rtl/wash_channel.sv
// One machine: settings, phase FSM and remaining-time counter.
// Commands arrive already decoded and priority-resolved.
module wash_channel
    import wash_seq_pkg::*;
#(
    parameter int VAL_W     = 5,
    parameter int MAX_CLOTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr,
    input  logic [1:0]       wr_field,
    input  logic [VAL_W-1:0] wr_data,
    input  logic             start,
    input  logic             abort,
    output logic [ST_W-1:0]  state,
    output logic [VAL_W-1:0] remaining,
    output logic             done,
    output logic             reject
);

    wash_state_e      state_q, state_d;
    logic [VAL_W-1:0] rem_q, rem_d;
    logic [VAL_W-1:0] wash_q, wash_d;
    logic [VAL_W-1:0] rinse_q, rinse_d;
    logic [VAL_W-1:0] spin_q, spin_d;
    logic [VAL_W-1:0] cloth_q, cloth_d;
    logic             done_q, done_d;
    logic             idle;
    logic             cloth_ok;
    logic             phase_end;

    // Phase progression first; accepted commands then override it.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wash_d    = wash_q;
        rinse_d   = rinse_q;
        spin_d    = spin_q;
        cloth_d   = cloth_q;
        done_d    = 1'b0;
        reject    = 1'b0;
        idle      = (state_q == ST_IDLE);
        cloth_ok  = (cloth_q != '0) &&
                    (cloth_q <= VAL_W'(MAX_CLOTH));
        phase_end = (rem_q == '0) ||
                    ((rem_q == VAL_W'(1)) && tick);

        unique case (state_q)
            ST_WASH: begin
                if (phase_end) begin
                    state_d = ST_RINSE;
                    rem_d   = rinse_q;
                end else if (tick) begin
                    rem_d = rem_q - VAL_W'(1);
                end
            end
            ST_RINSE: begin
                if (phase_end) begin
                    state_d = ST_SPIN;
                    rem_d   = spin_q;
                end else if (tick) begin
                    rem_d = rem_q - VAL_W'(1);
                end
            end
            ST_SPIN: begin
                if (phase_end) begin
                    state_d = ST_DONE;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else if (tick) begin
                    rem_d = rem_q - VAL_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
        endcase

        if (abort) begin
            if (!idle) begin
                state_d = ST_IDLE;
                rem_d   = '0;
                done_d  = 1'b0;
            end
        end else if (start) begin
            if (idle && cloth_ok) begin
                state_d = ST_WASH;
                rem_d   = wash_q;
            end else begin
                reject = 1'b1;
            end
        end else if (wr) begin
            if (idle) begin
                unique case (wr_field)
                    FLD_WASH:  wash_d  = wr_data;
                    FLD_RINSE: rinse_d = wr_data;
                    FLD_SPIN:  spin_d  = wr_data;
                    FLD_CLOTH: cloth_d = wr_data;
                endcase
            end else begin
                reject = 1'b1;
            end
        end
    end

    // State, counter and settings registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            wash_q  <= '0;
            rinse_q <= '0;
            spin_q  <= '0;
            cloth_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wash_q  <= wash_d;
            rinse_q <= rinse_d;
            spin_q  <= spin_d;
            cloth_q <= cloth_d;
            done_q  <= done_d;
        end
    end

    assign state     = state_q;
    assign remaining = rem_q;
    assign done      = done_q;

endmodule

// File: rtl/wash_seq_multi.sv
// Multi-machine wash sequencer: prescaler, command decode,
// priority resolution and error pulse around NUM_MACH channels.
module wash_seq_multi
    import wash_seq_pkg::*;
#(
    parameter int NUM_MACH  = 2,
    parameter int VAL_W     = 5,
    parameter int PRESCALE  = 10,
    parameter int MAX_CLOTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(NUM_MACH>1 ? $clog2(NUM_MACH) : 1)-1:0] sel,
    input  logic                      wr_en,
    input  logic [1:0]                wr_field,
    input  logic [VAL_W-1:0]          wr_data,
    input  logic                      start,
    input  logic                      abort,
    output logic [3*NUM_MACH-1:0]     state,
    output logic [VAL_W*NUM_MACH-1:0] remaining,
    output logic [NUM_MACH-1:0]       done,
    output logic                      err
);

    localparam int SEL_W = (NUM_MACH > 1) ? $clog2(NUM_MACH) : 1;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]     cnt_q, cnt_d;
    logic                tick;
    logic [NUM_MACH-1:0] hit;
    logic [NUM_MACH-1:0] ch_wr;
    logic [NUM_MACH-1:0] ch_start;
    logic [NUM_MACH-1:0] ch_abort;
    logic [NUM_MACH-1:0] ch_reject;
    logic                drop_err;
    logic                err_q, err_d;

    // Free-running time-unit prescaler shared by all machines.
    always_comb begin
        tick  = (cnt_q == PS_W'(PRESCALE - 1));
        cnt_d = tick ? '0 : cnt_q + PS_W'(1);
    end

    // Address decode with abort > start > write priority.
    always_comb begin
        hit      = '0;
        ch_wr    = '0;
        ch_start = '0;
        ch_abort = '0;
        for (int i = 0; i < NUM_MACH; i++) begin
            hit[i]      = (sel == SEL_W'(i));
            ch_abort[i] = hit[i] & abort;
            ch_start[i] = hit[i] & start & ~abort;
            ch_wr[i]    = hit[i] & wr_en & ~abort & ~start;
        end
        drop_err = (abort & (start | wr_en)) |
                   (start & wr_en) |
                   (~(|hit) & (start | wr_en));
        err_d    = drop_err | (|ch_reject);
    end

    // Prescaler and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

    for (genvar g = 0; g < NUM_MACH; g++) begin : g_ch
        wash_channel #(
            .VAL_W     (VAL_W),
            .MAX_CLOTH (MAX_CLOTH)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .wr        (ch_wr[g]),
            .wr_field  (wr_field),
            .wr_data   (wr_data),
            .start     (ch_start[g]),
            .abort     (ch_abort[g]),
            .state     (state[3*g +: 3]),
            .remaining (remaining[VAL_W*g +: VAL_W]),
            .done      (done[g]),
            .reject    (ch_reject[g])
        );
    end

endmodule

// File: tb/tb_wash_seq_multi.sv
// Scoreboard bench for wash_seq_multi: expected phase entries
// are queued per machine and matched on each observed change.
module tb_wash_seq_multi;

    localparam int NM = 2;
    localparam int VW = 5;
    localparam int PS = 2;
    localparam int MC = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [0:0]      sel;
    logic            wr_en;
    logic [1:0]      wr_field;
    logic [VW-1:0]   wr_data;
    logic            start;
    logic            abort;
    logic [3*NM-1:0] state;
    logic [VW*NM-1:0] remaining;
    logic [NM-1:0]   done;
    logic            err;

    typedef struct {
        int st;
        int rem;
        int lmin;
        int lmax;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   prev_st[NM];
    int   plen[NM];
    int   pmin[NM];
    int   pmax[NM];

    wash_seq_multi #(
        .NUM_MACH  (NM),
        .VAL_W     (VW),
        .PRESCALE  (PS),
        .MAX_CLOTH (MC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .wr_en     (wr_en),
        .wr_field  (wr_field),
        .wr_data   (wr_data),
        .start     (start),
        .abort     (abort),
        .state     (state),
        .remaining (remaining),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic void push(int m, int st, int rem,
                                 int lmin, int lmax);
        exp_t e;
        e.st   = st;
        e.rem  = rem;
        e.lmin = lmin;
        e.lmax = lmax;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int st_of(int m);
        return int'(state[3*m +: 3]);
    endfunction

    // Match every state change or done pulse to the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int m = 0; m < NM; m++) begin
                int   cur;
                bit   d;
                bit   have;
                exp_t e;
                cur = st_of(m);
                d   = done[m];
                if (cur != prev_st[m] || d) begin
                    if (pmin[m] >= 0) begin
                        chk("len_ge_min",
                            32'(plen[m] >= pmin[m]), 32'd1);
                        chk("len_le_max",
                            32'(plen[m] <= pmax[m]), 32'd1);
                    end
                    have = (m == 0) ? (q0.size() > 0)
                                    : (q1.size() > 0);
                    if (!have) begin
                        chk("unexp_evt", 32'(cur * 2 + int'(d)),
                            32'(prev_st[m] * 2));
                        pmin[m] = -1;
                    end else begin
                        if (m == 0) e = q0.pop_front();
                        else        e = q1.pop_front();
                        chk("state", 32'(cur), 32'(e.st));
                        chk("done", 32'(d), 32'(e.st == 4));
                        if (e.rem >= 0)
                            chk("remaining",
                                32'(remaining[VW*m +: VW]),
                                32'(e.rem));
                        pmin[m] = e.lmin;
                        pmax[m] = e.lmax;
                    end
                    plen[m]    = 1;
                    prev_st[m] = cur;
                end else begin
                    plen[m] = plen[m] + 1;
                end
            end
        end
    end

    task automatic cmd(input int s, input bit w, input int f,
                       input int dat, input bit st, input bit ab,
                       input bit exp_err);
        @(negedge clk);
        sel      = 1'(s);
        wr_en    = w;
        wr_field = 2'(f);
        wr_data  = VW'(dat);
        start    = st;
        abort    = ab;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        chk("err", 32'(err), 32'(exp_err));
        if (exp_err) begin
            @(negedge clk);
            chk("err_pulse", 32'(err), 32'd0);
        end
    endtask

    task automatic wr(input int s, input int f, input int dat);
        cmd(s, 1'b1, f, dat, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_st(input int m, input int st,
                           input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (st_of(m) == st) hit = 1'b1;
        end
        if (!hit) chk("timeout_state", 32'(st_of(m)), 32'(st));
    endtask

    task automatic wait_q(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
        if (q0.size() != 0 || q1.size() != 0)
            chk("timeout_queue",
                32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic push_run0(input int rinse_min,
                             input int rinse_max,
                             input int rinse_rem);
        push(0, 1, 3, 5, 6);
        push(0, 2, rinse_rem, rinse_min, rinse_max);
        push(0, 3, 1, 1, 2);
        push(0, 4, -1, 1, 1);
        push(0, 0, 0, -1, -1);
    endtask

    initial begin
        rst_n    = 1'b0;
        sel      = '0;
        wr_en    = 1'b0;
        wr_field = '0;
        wr_data  = '0;
        start    = 1'b0;
        abort    = 1'b0;
        for (int m = 0; m < NM; m++) begin
            prev_st[m] = 0;
            plen[m]    = 0;
            pmin[m]    = -1;
            pmax[m]    = -1;
        end
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_remaining", 32'(remaining), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        // Basic run on machine 0.
        wr(0, 0, 3);
        wr(0, 1, 2);
        wr(0, 2, 1);
        wr(0, 3, 2);
        push_run0(3, 4, 2);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_q(60);

        // Cloth out of range rejects start.
        wr(0, 3, 0);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("cloth0_idle", 32'(st_of(0)), 32'd0);
        wr(0, 3, 9);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("cloth9_idle", 32'(st_of(0)), 32'd0);
        wr(0, 3, 2);

        // Write while running is rejected.
        push_run0(3, 4, 2);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_st(0, 1, 10);
        cmd(0, 1'b1, 0, 7, 1'b0, 1'b0, 1'b1);
        wait_q(60);

        // Zero rinse holds RINSE for one cycle; wash still 3.
        wr(0, 1, 0);
        push_run0(1, 1, 0);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_q(60);

        // Abort machine 0 in RINSE while machine 1 runs.
        wr(0, 1, 2);
        wr(1, 0, 2);
        wr(1, 1, 2);
        wr(1, 2, 2);
        wr(1, 3, 1);
        push(1, 1, 2, 3, 4);
        push(1, 2, 2, 3, 4);
        push(1, 3, 2, 3, 4);
        push(1, 4, -1, 1, 1);
        push(1, 0, 0, -1, -1);
        push(0, 1, 3, 5, 6);
        push(0, 2, 2, -1, -1);
        push(0, 0, 0, -1, -1);
        cmd(1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_st(0, 2, 20);
        cmd(0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        chk("abort_idle", 32'(st_of(0)), 32'd0);
        wait_q(60);

        // Start and abort together: abort wins, err pulses.
        cmd(1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b1);
        chk("start_abort_idle", 32'(st_of(1)), 32'd0);

        // Asynchronous reset in SPIN.
        wr(0, 2, 3);
        push(0, 1, 3, 5, 6);
        push(0, 2, 2, 3, 4);
        push(0, 3, 3, -1, -1);
        cmd(0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        wait_st(0, 3, 40);
        #2;
        mon_en = 1'b0;
        chk("spin_popped", 32'(q0.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_remaining", 32'(remaining), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
